// File: rtl/mdu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_sequencer
//  Purpose  : Iterative multiply unit with HI/LO state for the EX stage.
//             Decodes mult/multu/mul/madd/msub and the HI/LO moves, runs a
//             shift-add multiply retiring STEPS multiplier bits per cycle,
//             and reports Busy/Done to the hazard unit.
//  Options  : define MDU_DIV_EN to add div/divu (restoring divider).
//  Revision : 1.0  initial release
// ============================================================================
module mdu_sequencer #(
    parameter int WIDTH = 32,
    parameter int STEPS = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Flush,
    input  logic [3:0]       AluOp,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic [WIDTH-1:0] Result
);

    localparam int N  = WIDTH / STEPS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int W2 = 2 * WIDTH;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_ACC  = 2'd2;
    localparam logic [1:0] c_S_DONE = 2'd3;

    localparam logic [3:0] c_OP_NONE  = 4'd0;
    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_MUL   = 4'd3;
    localparam logic [3:0] c_OP_MADD  = 4'd4;
    localparam logic [3:0] c_OP_MSUB  = 4'd5;
    localparam logic [3:0] c_OP_MTHI  = 4'd6;
    localparam logic [3:0] c_OP_MTLO  = 4'd7;
    localparam logic [3:0] c_OP_MFHI  = 4'd8;
    localparam logic [3:0] c_OP_MFLO  = 4'd9;
    localparam logic [3:0] c_OP_DIV   = 4'd10;
    localparam logic [3:0] c_OP_DIVU  = 4'd11;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [3:0]       r_op;
    logic [CW-1:0]    r_cnt;
    logic             r_neg;
    logic [W2-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [W2-1:0]    r_prod;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_res;

    logic [3:0]       w_dec_op;
    logic             w_dec_run;
    logic             w_dec_div;
    logic             w_dec_signed;
    logic             w_launch;
    logic             w_last;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [W2-1:0]    w_prod_step;
    logic [W2-1:0]    w_prod_fin;
    logic             w_run_div;
    logic [W2-1:0]    w_mcand_nxt;
    logic [WIDTH-1:0] w_mplier_nxt;
    logic [WIDTH-1:0] w_div_hi;
    logic [WIDTH-1:0] w_div_lo;

    // Translate the controller's AluOp/Funct pair into an internal op code
    always_comb begin
        w_dec_op = c_OP_NONE;
        case (AluOp)
            4'b0000: begin
                case (Funct)
                    6'b011000: w_dec_op = c_OP_MULT;
                    6'b011001: w_dec_op = c_OP_MULTU;
                    6'b010001: w_dec_op = c_OP_MTHI;
                    6'b010011: w_dec_op = c_OP_MTLO;
                    6'b010000: w_dec_op = c_OP_MFHI;
                    6'b010010: w_dec_op = c_OP_MFLO;
`ifdef MDU_DIV_EN
                    6'b011010: w_dec_op = c_OP_DIV;
                    6'b011011: w_dec_op = c_OP_DIVU;
`endif
                    default:   w_dec_op = c_OP_NONE;
                endcase
            end
            4'b1100: begin
                case (Funct)
                    6'b000010: w_dec_op = c_OP_MUL;
                    6'b000000: w_dec_op = c_OP_MADD;
                    6'b000100: w_dec_op = c_OP_MSUB;
                    default:   w_dec_op = c_OP_NONE;
                endcase
            end
            4'b1001: w_dec_op = c_OP_MULTU;
            default: w_dec_op = c_OP_NONE;
        endcase
    end

    assign w_dec_div    = (w_dec_op == c_OP_DIV) || (w_dec_op == c_OP_DIVU);
    assign w_dec_run    = (w_dec_op == c_OP_MULT) || (w_dec_op == c_OP_MULTU) ||
                          (w_dec_op == c_OP_MUL)  || (w_dec_op == c_OP_MADD)  ||
                          (w_dec_op == c_OP_MSUB) || w_dec_div;
    assign w_dec_signed = (w_dec_op == c_OP_MULT) || (w_dec_op == c_OP_MUL)  ||
                          (w_dec_op == c_OP_MADD) || (w_dec_op == c_OP_MSUB) ||
                          (w_dec_op == c_OP_DIV);

    // Flush in IDLE suppresses a simultaneous Start
    assign w_launch = (r_state == c_S_IDLE) && Start && !Flush && (w_dec_op != c_OP_NONE);
    assign w_last   = (r_cnt == '0);

    // Work on magnitudes; the most-negative value maps to 2^(W-1), which fits unsigned
    assign w_a_neg = w_dec_signed && A[WIDTH-1];
    assign w_b_neg = w_dec_signed && B[WIDTH-1];
    assign w_a_mag = w_a_neg ? (-A) : A;
    assign w_b_mag = w_b_neg ? (-B) : B;

    // One shift-add step over STEPS multiplier bits, then sign correction
    always_comb begin
        w_prod_step = r_prod;
        for (int j = 0; j < STEPS; j++) begin
            if (r_mplier[j]) begin
                w_prod_step = w_prod_step + (r_mcand << j);
            end
        end
        w_prod_fin = r_neg ? (-w_prod_step) : w_prod_step;
    end

`ifdef MDU_DIV_EN
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_a_raw;
    logic             r_divz;
    logic             r_rneg;
    logic [WIDTH:0]   w_rem;
    logic [WIDTH-1:0] w_quo;

    // Restoring division step: dividend bits shift out of r_mplier, quotient bits shift in
    always_comb begin
        w_rem = r_rem;
        w_quo = r_mplier;
        for (int j = 0; j < STEPS; j++) begin
            w_rem = {w_rem[WIDTH-1:0], w_quo[WIDTH-1]};
            w_quo = {w_quo[WIDTH-2:0], 1'b0};
            if (w_rem >= {1'b0, r_mcand[WIDTH-1:0]}) begin
                w_rem    = w_rem - {1'b0, r_mcand[WIDTH-1:0]};
                w_quo[0] = 1'b1;
            end
        end
    end

    // Divider-only state: remainder, raw dividend for the divide-by-zero case, signs
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_rem   <= '0;
            r_a_raw <= '0;
            r_divz  <= 1'b0;
            r_rneg  <= 1'b0;
        end else if (w_launch) begin
            r_rem   <= '0;
            r_a_raw <= A;
            r_divz  <= (B == '0);
            r_rneg  <= w_a_neg;
        end else if ((r_state == c_S_RUN) && !Flush) begin
            r_rem   <= w_rem;
        end
    end

    assign w_run_div    = (r_op == c_OP_DIV) || (r_op == c_OP_DIVU);
    assign w_mcand_nxt  = w_run_div ? r_mcand : (r_mcand << STEPS);
    assign w_mplier_nxt = w_run_div ? w_quo : (r_mplier >> STEPS);
    // Quotient truncates toward zero; remainder follows the dividend's sign
    assign w_div_lo     = r_divz ? '1 : (r_neg ? (-w_quo) : w_quo);
    assign w_div_hi     = r_divz ? r_a_raw :
                          (r_rneg ? (-w_rem[WIDTH-1:0]) : w_rem[WIDTH-1:0]);
`else
    assign w_run_div    = 1'b0;
    assign w_mcand_nxt  = r_mcand << STEPS;
    assign w_mplier_nxt = r_mplier >> STEPS;
    assign w_div_lo     = '0;
    assign w_div_hi     = '0;
`endif

    // State register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: moves finish in one cycle, multiplies run N cycles, madd/msub add ACC
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_launch) begin
                    w_state_nxt = w_dec_run ? c_S_RUN : c_S_DONE;
                end
            end
            c_S_RUN: begin
                if (Flush) begin
                    w_state_nxt = c_S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = ((r_op == c_OP_MADD) || (r_op == c_OP_MSUB)) ? c_S_ACC : c_S_DONE;
                end
            end
            c_S_ACC:  w_state_nxt = Flush ? c_S_IDLE : c_S_DONE;
            c_S_DONE: w_state_nxt = c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    // Status outputs decoded from the current state
    always_comb begin
        Busy = (r_state != c_S_IDLE);
        Done = (r_state == c_S_DONE);
    end

    // Datapath: latch operands at launch, iterate in RUN, write back on entry to DONE
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_op     <= c_OP_NONE;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_res    <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_launch) begin
                        r_op     <= w_dec_op;
                        r_cnt    <= CW'(N - 1);
                        r_neg    <= w_a_neg ^ w_b_neg;
                        r_prod   <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, (w_dec_div ? w_b_mag : w_a_mag)};
                        r_mplier <= w_dec_div ? w_a_mag : w_b_mag;
                        case (w_dec_op)
                            c_OP_MTHI: r_hi  <= A;
                            c_OP_MTLO: r_lo  <= A;
                            c_OP_MFHI: r_res <= r_hi;
                            c_OP_MFLO: r_res <= r_lo;
                            default:   ;
                        endcase
                    end
                end
                c_S_RUN: begin
                    if (!Flush) begin
                        r_prod   <= w_prod_step;
                        r_mcand  <= w_mcand_nxt;
                        r_mplier <= w_mplier_nxt;
                        r_cnt    <= r_cnt - CW'(1);
                        if (w_last) begin
                            case (r_op)
                                c_OP_MULT, c_OP_MULTU: {r_hi, r_lo} <= w_prod_fin;
                                c_OP_MUL:              r_res <= w_prod_fin[WIDTH-1:0];
                                c_OP_MADD, c_OP_MSUB:  r_prod <= w_prod_fin;
                                c_OP_DIV, c_OP_DIVU: begin
                                    r_hi <= w_div_hi;
                                    r_lo <= w_div_lo;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                c_S_ACC: begin
                    if (!Flush) begin
                        {r_hi, r_lo} <= (r_op == c_OP_MADD) ? ({r_hi, r_lo} + r_prod)
                                                            : ({r_hi, r_lo} - r_prod);
                    end
                end
                default: ;
            endcase
        end
    end

    assign Hi     = r_hi;
    assign Lo     = r_lo;
    assign Result = r_res;

endmodule
`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mdu_sequencer
//  Purpose  : Self-checking bench for mdu_sequencer (WIDTH=32, STEPS=1):
//             directed vector table, multi-cycle corner sequences, and a
//             randomized run against a 64-bit arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mdu_sequencer;

    localparam int W = 32;

    logic         Clk;
    logic         Rst;
    logic         Start;
    logic         Flush;
    logic [3:0]   AluOp;
    logic [5:0]   Funct;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Hi;
    logic [W-1:0] Lo;
    logic [W-1:0] Result;

    int n_checks = 0;
    int n_errors = 0;

    // Reference HI/LO/Result as the bench believes they should be
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic [W-1:0] m_res = '0;

    mdu_sequencer #(.WIDTH(W), .STEPS(1)) u_dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Flush(Flush),
        .AluOp(AluOp), .Funct(Funct), .A(A), .B(B),
        .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo), .Result(Result)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0]   op;
        logic [5:0]   fn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic [W-1:0] res;
        int           lat;   // 0 = op must be ignored
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [3:0] op, input logic [5:0] fn,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] hi, input logic [W-1:0] lo,
                                input logic [W-1:0] res, input int lat);
        vec_t v;
        v.op = op; v.fn = fn; v.a = a; v.b = b;
        v.hi = hi; v.lo = lo; v.res = res; v.lat = lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op at a negedge, wait (bounded) for Done, check latency and results.
    // Returns at the negedge inside the Done cycle (or after the idle window).
    task automatic do_op(input string name, input logic [3:0] op, input logic [5:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eh, input logic [W-1:0] el,
                         input logic [W-1:0] er, input int exp_lat);
        int lat;
        bit ok;
        @(negedge Clk);
        Start = 1'b1; AluOp = op; Funct = fn; A = a; B = b;
        @(negedge Clk);
        Start = 1'b0; A = $urandom; B = $urandom;
        lat = 1;
        ok  = 1'b1;
        if (exp_lat == 0) begin
            repeat (3) begin
                if (Busy || Done) ok = 1'b0;
                @(negedge Clk);
            end
            check({name, " ignored"}, W'(ok), W'(1));
        end else begin
            while (!Done && lat < 100) begin
                if (!Busy) ok = 1'b0;
                @(negedge Clk);
                lat++;
            end
            if (!Busy) ok = 1'b0;
            check({name, " latency"}, W'(lat), W'(exp_lat));
            check({name, " busy"}, W'(ok), W'(1));
        end
        check({name, " hi"}, Hi, eh);
        check({name, " lo"}, Lo, el);
        check({name, " result"}, Result, er);
        m_hi = eh; m_lo = el; m_res = er;
    endtask

    // Reference model: plain 64-bit arithmetic on the instruction semantics
    task automatic model(input int kind, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat);
        longint       sa, sb;
        logic [63:0]  sp, up, acc;
        sa  = $signed(a);
        sb  = $signed(b);
        sp  = 64'(sa * sb);
        up  = {32'b0, a} * {32'b0, b};
        acc = {m_hi, m_lo};
        lat = 33;
        case (kind)
            0: {m_hi, m_lo} = sp;
            1: {m_hi, m_lo} = up;
            2: m_res = sp[31:0];
            3: begin {m_hi, m_lo} = acc + sp; lat = 34; end
            4: begin {m_hi, m_lo} = acc - sp; lat = 34; end
            5: begin m_hi = a; lat = 1; end
            6: begin m_lo = a; lat = 1; end
            7: begin m_res = m_hi; lat = 1; end
            default: begin m_res = m_lo; lat = 1; end
        endcase
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h0000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    logic [3:0] k_op [9] = '{4'b0000, 4'b0000, 4'b1100, 4'b1100, 4'b1100,
                             4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [5:0] k_fn [9] = '{6'b011000, 6'b011001, 6'b000010, 6'b000000, 6'b000100,
                             6'b010001, 6'b010011, 6'b010000, 6'b010010};

    initial begin
        int lat;
        int kind;
        bit ok;
        logic [W-1:0] ra, rb;
        logic [3:0]   rop;
        logic [5:0]   rfn;

        Rst = 1'b1; Start = 1'b0; Flush = 1'b0;
        AluOp = '0; Funct = '0; A = '0; B = '0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge Clk);
        check("reset busy", W'(Busy), W'(0));
        check("reset done", W'(Done), W'(0));
        check("reset hi", Hi, '0);
        check("reset lo", Lo, '0);
        check("reset result", Result, '0);
        Rst = 1'b0;

        // ---------------- directed vector table (state carries row to row) ----------------
        tbl.push_back(mk(4'b0000, 6'b011000, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 32'h00000000, 33));
        tbl.push_back(mk(4'b0000, 6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'h00000000, 33));
        tbl.push_back(mk(4'b1100, 6'b000010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFE, 33));
        tbl.push_back(mk(4'b0000, 6'b010001, 32'h12345678, 32'h00000000, 32'h12345678, 32'h00000001, 32'hFFFFFFFE, 1));
        tbl.push_back(mk(4'b0000, 6'b010011, 32'h00000000, 32'h00000000, 32'h12345678, 32'h00000000, 32'hFFFFFFFE, 1));
        tbl.push_back(mk(4'b1100, 6'b000000, 32'h00000002, 32'h00000003, 32'h12345678, 32'h00000006, 32'hFFFFFFFE, 34));
        tbl.push_back(mk(4'b1100, 6'b000100, 32'h00000001, 32'h00000010, 32'h12345677, 32'hFFFFFFF6, 32'hFFFFFFFE, 34));
        tbl.push_back(mk(4'b0000, 6'b010000, 32'h00000000, 32'h00000000, 32'h12345677, 32'hFFFFFFF6, 32'h12345677, 1));
        tbl.push_back(mk(4'b0000, 6'b010010, 32'h00000000, 32'h00000000, 32'h12345677, 32'hFFFFFFF6, 32'hFFFFFFF6, 1));
        tbl.push_back(mk(4'b0000, 6'b100000, 32'h00000001, 32'h00000001, 32'h12345677, 32'hFFFFFFF6, 32'hFFFFFFF6, 0));
        tbl.push_back(mk(4'b0101, 6'b011000, 32'h00000001, 32'h00000001, 32'h12345677, 32'hFFFFFFF6, 32'hFFFFFFF6, 0));
        tbl.push_back(mk(4'b0000, 6'b011000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 32'hFFFFFFF6, 33));
        tbl.push_back(mk(4'b1001, 6'b000000, 32'h80000000, 32'h00000003, 32'h00000001, 32'h80000000, 32'hFFFFFFF6, 33));
        tbl.push_back(mk(4'b1100, 6'b000010, 32'hFFFFFFF9, 32'hFFFFFFFD, 32'h00000001, 32'h80000000, 32'h00000015, 33));
        tbl.push_back(mk(4'b1100, 6'b000100, 32'h80000000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000015, 34));
        tbl.push_back(mk(4'b1100, 6'b000000, 32'h7FFFFFFF, 32'h80000000, 32'hC0000001, 32'h80000000, 32'h00000015, 34));
        tbl.push_back(mk(4'b0000, 6'b011000, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 32'h00000015, 33));
        for (int i = 0; i < tbl.size(); i++) begin
            do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].fn, tbl[i].a, tbl[i].b,
                  tbl[i].hi, tbl[i].lo, tbl[i].res, tbl[i].lat);
        end

        // ---------------- divide codes ----------------
`ifdef MDU_DIV_EN
        do_op("div", 4'b0000, 6'b011010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, m_res, 33);
        do_op("divu0", 4'b0000, 6'b011011, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, m_res, 33);
`else
        do_op("div off", 4'b0000, 6'b011010, 32'h00000007, 32'h00000002, m_hi, m_lo, m_res, 0);
        do_op("divu off", 4'b0000, 6'b011011, 32'h00000007, 32'h00000002, m_hi, m_lo, m_res, 0);
`endif

        // ---------------- Start while Busy (RUN and DONE) is ignored ----------------
        @(negedge Clk);
        Start = 1'b1; AluOp = 4'b0000; Funct = 6'b011000; A = 32'd5; B = 32'd6;
        @(negedge Clk);
        Start = 1'b0; lat = 1;
        repeat (4) begin @(negedge Clk); lat++; end
        Start = 1'b1; Funct = 6'b010001; A = 32'hDEADBEEF;
        @(negedge Clk);
        lat++; Start = 1'b0;
        while (!Done && lat < 100) begin @(negedge Clk); lat++; end
        check("busy-start latency", W'(lat), W'(33));
        check("busy-start hi", Hi, 32'h0);
        check("busy-start lo", Lo, 32'd30);
        Start = 1'b1; Funct = 6'b010001; A = 32'hCAFEF00D;
        @(negedge Clk);
        Start = 1'b0;
        check("done-start busy", W'(Busy), W'(0));
        check("done-start hi", Hi, 32'h0);
        m_hi = 32'h0; m_lo = 32'd30;

        // ---------------- Flush in RUN at cycle 10 ----------------
        @(negedge Clk);
        Start = 1'b1; Funct = 6'b011000; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
        @(negedge Clk);
        Start = 1'b0;
        repeat (9) @(negedge Clk);
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        check("flush-run busy", W'(Busy), W'(0));
        ok = 1'b1;
        repeat (40) begin if (Done || Busy) ok = 1'b0; @(negedge Clk); end
        check("flush-run no done", W'(ok), W'(1));
        check("flush-run hi", Hi, m_hi);
        check("flush-run lo", Lo, m_lo);

        // ---------------- Flush in ACC (cycle N+1 of madd) ----------------
        Start = 1'b1; AluOp = 4'b1100; Funct = 6'b000000; A = 32'd9; B = 32'd9;
        @(negedge Clk);
        Start = 1'b0;
        repeat (32) @(negedge Clk);
        check("acc busy", W'(Busy && !Done), W'(1));
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        check("flush-acc busy", W'(Busy || Done), W'(0));
        check("flush-acc hi", Hi, m_hi);
        check("flush-acc lo", Lo, m_lo);

        // ---------------- Flush in DONE: writeback stands ----------------
        Start = 1'b1; AluOp = 4'b0000; Funct = 6'b010001; A = 32'hA5A5A5A5;
        @(negedge Clk);
        Start = 1'b0;
        check("flush-done pulse", W'(Done), W'(1));
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        check("flush-done hi", Hi, 32'hA5A5A5A5);
        check("flush-done busy", W'(Busy), W'(0));
        m_hi = 32'hA5A5A5A5;

        // ---------------- Flush and Start together in IDLE ----------------
        Start = 1'b1; Flush = 1'b1; Funct = 6'b010011; A = 32'h11111111;
        @(negedge Clk);
        Start = 1'b0; Flush = 1'b0;
        ok = 1'b1;
        repeat (3) begin if (Busy || Done) ok = 1'b0; @(negedge Clk); end
        check("flush-start idle", W'(ok), W'(1));
        check("flush-start lo", Lo, m_lo);

        // ---------------- asynchronous reset mid-RUN ----------------
        Start = 1'b1; Funct = 6'b011000; A = 32'd3; B = 32'd4;
        @(negedge Clk);
        Start = 1'b0;
        repeat (9) @(negedge Clk);
        #2 Rst = 1'b1;
        #1;
        check("async rst busy", W'(Busy), W'(0));
        check("async rst done", W'(Done), W'(0));
        check("async rst hi", Hi, '0);
        check("async rst lo", Lo, '0);
        check("async rst result", Result, '0);
        @(negedge Clk);
        Rst = 1'b0;
        m_hi = '0; m_lo = '0; m_res = '0;

        // ---------------- randomized ops against the reference model ----------------
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 8);
            ra   = pick();
            rb   = pick();
            rop  = k_op[kind];
            rfn  = k_fn[kind];
            if (kind == 1 && $urandom_range(0, 1) == 1) begin
                rop = 4'b1001;
                rfn = 6'($urandom);
            end
            model(kind, ra, rb, lat);
            do_op($sformatf("rnd%0d k%0d", i, kind), rop, rfn, ra, rb, m_hi, m_lo, m_res, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
